// File: rtl/mips_cpu_core.sv
// Single-cycle 32-bit MIPS core: PC, register file, extender, ALU, next-PC.
// Instruction and data memories sit outside; this block drives their ports.
module mips_cpu_core #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] DataToWd,
  output logic [31:0] ALU_result,
  output logic [31:0] Ext_Imm,
  output logic [31:0] addr,
  output logic [31:0] Out1,
  output logic [31:0] Out2,
  output logic        MemWrite,
  output logic        MemtoReg
);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    alu_src;
    logic    zero_ext;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign funct  = Instruction[5:0];
  assign imm    = Instruction[15:0];
  assign target = Instruction[25:0];

  logic [31:0] pc;
  logic [31:0] regs [32];
  ctrl_t       ctrl;
  logic [31:0] alu_b;
  logic        zero;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;

  // Opcode/funct decode; anything unrecognised stays an all-zero NOP.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    unique case (1'b1)
      (op == OP_R): begin
        ctrl.reg_dst = 1'b1;
        case (funct)
          FN_ADD: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_ADD;
          end
          FN_SUB: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_SUB;
          end
          FN_AND: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_AND;
          end
          FN_OR: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_OR;
          end
          FN_SLT: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_SLT;
          end
          default: ctrl.reg_dst = 1'b0;
        endcase
      end
      (op == OP_ADDI): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      (op == OP_ANDI): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        ctrl.alu_op    = ALU_AND;
      end
      (op == OP_ORI): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.zero_ext  = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      (op == OP_LW): begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      (op == OP_SW): begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      (op == OP_BEQ): begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      (op == OP_J): begin
        ctrl.jump = 1'b1;
      end
      default: ;
    endcase
  end

  assign Ext_Imm = ctrl.zero_ext ? {16'h0000, imm}
                                 : {{16{imm[15]}}, imm};

  assign Out1 = (rs == 5'd0) ? 32'h0 : regs[rs];
  assign Out2 = (rt == 5'd0) ? 32'h0 : regs[rt];

  assign alu_b = ctrl.alu_src ? Ext_Imm : Out2;

  // ALU; add/sub wrap, slt is a signed compare.
  always_comb begin
    ALU_result = 32'h0;
    case (ctrl.alu_op)
      ALU_ADD: ALU_result = Out1 + alu_b;
      ALU_SUB: ALU_result = Out1 - alu_b;
      ALU_AND: ALU_result = Out1 & alu_b;
      ALU_OR:  ALU_result = Out1 | alu_b;
      ALU_SLT: ALU_result = {31'h0, $signed(Out1) < $signed(alu_b)};
      default: ALU_result = 32'h0;
    endcase
  end

  assign zero     = (ALU_result == 32'h0);
  assign MemWrite = ctrl.mem_write & Reset;
  assign MemtoReg = ctrl.mem_to_reg;
  assign wr_addr  = ctrl.reg_dst ? rd : rt;
  assign wr_data  = ctrl.mem_to_reg ? DataToWd : ALU_result;

  // Next-PC selection: jump, taken branch, or fall through.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    pc_next  = pc_plus4;
    if (ctrl.jump)
      pc_next = {pc_plus4[31:28], target, 2'b00};
    else if (ctrl.branch && zero)
      pc_next = pc_plus4 + (Ext_Imm << 2);
  end

  assign addr = pc;

  // Program counter register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      pc <= PC_RESET;
    else
      pc <= pc_next;
  end

  // Register file; $0 is never written so it always reads zero.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'h0;
    end else if (ctrl.reg_write && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mips_cpu_core.sv
// Directed bench for mips_cpu_core: vector table plus reset
// and branch sequences.
module tb_mips_cpu_core;

  logic        Clock;
  logic        Reset;
  logic [31:0] Instruction;
  logic [31:0] DataToWd;
  logic [31:0] ALU_result;
  logic [31:0] Ext_Imm;
  logic [31:0] addr;
  logic [31:0] Out1;
  logic [31:0] Out2;
  logic        MemWrite;
  logic        MemtoReg;

  mips_cpu_core #(.PC_RESET(32'h0)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Instruction(Instruction),
    .DataToWd   (DataToWd),
    .ALU_result (ALU_result),
    .Ext_Imm    (Ext_Imm),
    .addr       (addr),
    .Out1       (Out1),
    .Out2       (Out2),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  localparam logic [3:0] M_O1 = 4'b0001;
  localparam logic [3:0] M_O2 = 4'b0010;
  localparam logic [3:0] M_AL = 4'b0100;
  localparam logic [3:0] M_EX = 4'b1000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] dmem;
    logic [3:0]  mask;
    logic [31:0] e_addr;
    logic [31:0] e_out1;
    logic [31:0] e_out2;
    logic [31:0] e_alu;
    logic [31:0] e_ext;
    logic        e_mw;
    logic        e_mtr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] r_op(input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] d,
    input logic [3:0] m, input logic [31:0] a, input logic [31:0] o1,
    input logic [31:0] o2, input logic [31:0] al, input logic [31:0] ex,
    input logic mw, input logic mtr);
    vec_t v;
    v.instr = i; v.dmem = d; v.mask = m; v.e_addr = a;
    v.e_out1 = o1; v.e_out2 = o2; v.e_alu = al; v.e_ext = ex;
    v.e_mw = mw; v.e_mtr = mtr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
    input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [31:0] i, input logic [31:0] d);
    Instruction = i;
    DataToWd    = d;
    #1;
  endtask

  vec_t tbl [23];

  initial begin
    tbl[0]  = mk(32'h0, 0, M_O1 | M_O2, 32'h00, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(32'h0, 0, 4'h0, 32'h04, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(32'h0, 0, 4'h0, 32'h08, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(i_op(6'h08, 0, 1, 16'd5), 0, M_O1 | M_AL | M_EX,
                 32'h0C, 0, 0, 32'd5, 32'd5, 0, 0);
    tbl[4]  = mk(i_op(6'h08, 0, 2, 16'hFFFD), 0, M_AL | M_EX,
                 32'h10, 0, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 0, 0);
    tbl[5]  = mk(r_op(1, 2, 3, 6'h20), 0, M_O1 | M_O2 | M_AL,
                 32'h14, 32'd5, 32'hFFFF_FFFD, 32'd2, 0, 0, 0);
    tbl[6]  = mk(r_op(1, 2, 4, 6'h22), 0, M_AL,
                 32'h18, 0, 0, 32'd8, 0, 0, 0);
    tbl[7]  = mk(r_op(2, 1, 5, 6'h2A), 0, M_O1 | M_O2 | M_AL,
                 32'h1C, 32'hFFFF_FFFD, 32'd5, 32'd1, 0, 0, 0);
    tbl[8]  = mk(r_op(3, 4, 8, 6'h24), 0, M_O1 | M_O2 | M_AL,
                 32'h20, 32'd2, 32'd8, 32'd0, 0, 0, 0);
    tbl[9]  = mk(r_op(5, 3, 9, 6'h25), 0, M_O1 | M_O2 | M_AL,
                 32'h24, 32'd1, 32'd2, 32'd3, 0, 0, 0);
    tbl[10] = mk(i_op(6'h2B, 0, 1, 16'd4), 0, M_O2 | M_AL | M_EX,
                 32'h28, 0, 32'd5, 32'd4, 32'd4, 1, 0);
    tbl[11] = mk(i_op(6'h23, 0, 6, 16'd8), 32'h1234, M_O2 | M_AL,
                 32'h2C, 0, 32'd0, 32'd8, 0, 0, 1);
    tbl[12] = mk(r_op(6, 1, 10, 6'h25), 0, M_O1 | M_O2 | M_AL,
                 32'h30, 32'h1234, 32'd5, 32'h1235, 0, 0, 0);
    tbl[13] = mk(i_op(6'h04, 1, 1, 16'd2), 0, M_AL | M_EX,
                 32'h34, 0, 0, 32'd0, 32'd2, 0, 0);
    tbl[14] = mk(i_op(6'h04, 1, 2, 16'd2), 0, M_AL,
                 32'h40, 0, 0, 32'd8, 0, 0, 0);
    tbl[15] = mk({6'h02, 26'h40}, 0, 4'h0,
                 32'h44, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(i_op(6'h08, 0, 0, 16'd7), 0, M_AL | M_EX,
                 32'h100, 0, 0, 32'd7, 32'd7, 0, 0);
    tbl[17] = mk(i_op(6'h0D, 0, 7, 16'hFFFF), 0, M_O1 | M_AL | M_EX,
                 32'h104, 0, 0, 32'h0000_FFFF, 32'h0000_FFFF, 0, 0);
    tbl[18] = mk(r_op(7, 0, 11, 6'h20), 0, M_O1 | M_O2,
                 32'h108, 32'h0000_FFFF, 0, 0, 0, 0, 0);
    tbl[19] = mk(i_op(6'h3F, 0, 1, 16'h1234), 0, 4'h0,
                 32'h10C, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(r_op(2, 2, 1, 6'h21), 0, 4'h0,
                 32'h110, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(r_op(1, 2, 13, 6'h2A), 0, M_O1 | M_AL,
                 32'h114, 32'd5, 0, 32'd0, 0, 0, 0);
    tbl[22] = mk(r_op(2, 1, 14, 6'h22), 0, M_AL,
                 32'h118, 0, 0, 32'hFFFF_FFF8, 0, 0, 0);

    Reset       = 1'b0;
    Instruction = i_op(6'h2B, 0, 1, 16'd4);
    DataToWd    = 32'h0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_addr", addr, 32'h0);
    chk("rst_memwrite", {31'h0, MemWrite}, 32'h0);
    chk("rst_out2", Out2, 32'h0);

    @(negedge Clock);
    Reset = 1'b1;
    for (int k = 0; k < 23; k++) begin
      apply(tbl[k].instr, tbl[k].dmem);
      chk($sformatf("v%0d_addr", k), addr, tbl[k].e_addr);
      chk($sformatf("v%0d_memwrite", k), {31'h0, MemWrite},
          {31'h0, tbl[k].e_mw});
      chk($sformatf("v%0d_memtoreg", k), {31'h0, MemtoReg},
          {31'h0, tbl[k].e_mtr});
      if (tbl[k].mask[0])
        chk($sformatf("v%0d_out1", k), Out1, tbl[k].e_out1);
      if (tbl[k].mask[1])
        chk($sformatf("v%0d_out2", k), Out2, tbl[k].e_out2);
      if (tbl[k].mask[2])
        chk($sformatf("v%0d_alu", k), ALU_result, tbl[k].e_alu);
      if (tbl[k].mask[3])
        chk($sformatf("v%0d_ext", k), Ext_Imm, tbl[k].e_ext);
      @(negedge Clock);
    end

    #3;
    Reset = 1'b0;
    Instruction = r_op(1, 14, 15, 6'h20);
    #1;
    chk("async_rst_addr", addr, 32'h0);
    chk("async_rst_out1", Out1, 32'h0);
    chk("async_rst_out2", Out2, 32'h0);

    @(negedge Clock);
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply(32'h0, 0);
      chk($sformatf("nop%0d_addr", k), addr, 32'(k * 4));
      @(negedge Clock);
    end
    apply(i_op(6'h04, 1, 1, 16'd2), 0);
    chk("beq_eq_at", addr, 32'h10);
    @(negedge Clock);
    apply(i_op(6'h08, 0, 1, 16'd1), 0);
    chk("beq_eq_target", addr, 32'h1C);
    @(negedge Clock);
    apply(i_op(6'h04, 1, 0, 16'd2), 0);
    chk("beq_ne_at", addr, 32'h20);
    chk("beq_ne_out1", Out1, 32'd1);
    @(negedge Clock);
    apply(i_op(6'h04, 0, 0, 16'hFFFF), 0);
    chk("beq_ne_fall", addr, 32'h24);
    @(negedge Clock);
    apply(i_op(6'h0C, 1, 16, 16'h8003), 0);
    chk("beq_back_target", addr, 32'h24);
    chk("andi_ext", Ext_Imm, 32'h0000_8003);
    chk("andi_alu", ALU_result, 32'd1);
    @(negedge Clock);
    apply(r_op(16, 0, 17, 6'h20), 0);
    chk("andi_wb", Out1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_core.md
Name: mips_cpu_core

Overview:
- Single-cycle 32-bit MIPS datapath plus control: PC, 32x32 register file, sign/zero extender, ALU, next-PC logic.
- Exports the PC as `addr` to an external instruction ROM. The fetched word returns on `Instruction`.
- Exports ALU result, store data and control strobes to an external data RAM. Load data returns on `DataToWd`.

Parameters:
- PC_RESET, 32'h0000_0000, PC value while reset is asserted.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Instruction  in  32  current instruction word, fetched from `addr`.
- DataToWd  in  32  data-memory read data, written back on loads.
- ALU_result  out  32  ALU output; also the data-memory address.
- Ext_Imm  out  32  extended 16-bit immediate.
- addr  out  32  current PC (byte address).
- Out1  out  32  register-file read data for rs.
- Out2  out  32  register-file read data for rt; also the store data.
- MemWrite  out  1  data-memory write enable (sw).
- MemtoReg  out  1  write-back source select (1 = DataToWd).

Behaviour:
- Reset low (asynchronous):
  - PC = PC_RESET; all 32 registers cleared to 0.
  - MemWrite forced 0; no register write occurs.
- All outputs other than state are combinational from Instruction and the current state.
- Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0], target=[25:0].
- Supported instructions:
  - R-type (op 0): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - I-type: addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02.
- Ext_Imm: zero-extend for andi/ori; sign-extend for all other opcodes.
- ALU:
  - add/sub wrap modulo 2^32; no overflow trap.
  - slt is a signed compare producing 1 or 0.
  - ALU operand B = Out2 for R-type and beq; Ext_Imm for addi/andi/ori/lw/sw.
  - beq performs a subtract; zero flag = (result == 0).
- Register write:
  - Enabled for R-type, addi, andi, ori, lw.
  - Destination = rd for R-type, rt otherwise.
  - Write data = DataToWd when MemtoReg=1 (lw only), else ALU_result.
  - Write occurs on the rising edge.
  - Writes to $0 are discarded; reads of $0 return 0.
  - Reads are combinational and return the pre-edge value; there is no write-through bypass.
- Next PC (rising edge):
  - Default PC+4.
  - beq taken: PC+4+(sign-extended imm << 2).
  - j: {PC+4[31:28], target, 2'b00}.
- Unsupported opcode or funct: behaves as NOP. No register or memory write; PC+4. MemWrite=0, MemtoReg=0.
- PC and memory addresses are not alignment-checked; PC wraps at 2^32.
- Reset released mid-cycle: the first instruction at PC_RESET executes on the next rising edge.

Test Plan:
- Hold Reset=0 for 2 cycles, then release → addr=0; Out1=Out2=0 for any instruction; MemWrite=0. On subsequent edges, with NOPs (0x00000000), addr steps 0, 4, 8.
- Execute `addi $1,$0,5` then `addi $2,$0,-3` → after 2 edges, $1=5 and $2=0xFFFFFFFD. Ext_Imm=0xFFFFFFFD during the second instruction.
- With those values, execute `add $3,$1,$2`, `sub $4,$1,$2`, `slt $5,$2,$1` → $3=2, $4=8, $5=1. Check $3 via Out1 of a later instruction.
- Execute `sw $1,4($0)` → MemWrite=1, ALU_result=4, Out2=5, no register change. Then execute `lw $6,8($0)` with DataToWd=0x1234 → MemtoReg=1; $6=0x1234 after the edge.
- At PC=0x10, execute `beq $1,$1,+2` → next addr=0x1C. With unequal registers → next addr=0x14. Then execute `j 0x40` → next addr=0x100.
- Execute `addi $0,$0,7`, then `ori $7,$0,0xFFFF` → $0 still reads 0; $7=0x0000FFFF (zero-extended). Assert Reset mid-run → addr=0 and registers clear immediately, without waiting for a clock edge.
